// File: rtl/lif_neuron_refractory.sv
// Leaky integrate-and-fire neuron with saturating potential and refractory period.
// Ports: clk/reset, enable, input_current, threshold, refractory_period -> membrane_potential, spike_out, refractory.
module lif_neuron_refractory #(
  parameter int                 DECAY_SHIFT = 3,
  parameter logic signed [7:0]  V_RESET     = 8'sd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic signed [7:0] input_current,
  input  logic [7:0]        threshold,
  input  logic [7:0]        refractory_period,
  output logic signed [7:0] membrane_potential,
  output logic              spike_out,
  output logic              refractory
);

  typedef enum logic {
    ST_INT = 1'b0,
    ST_REF = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  v_q, v_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        spk_q, spk_d;
  logic        ref_q, ref_d;

  logic signed [9:0] v_ext;
  logic signed [9:0] i_ext;
  logic signed [9:0] leak;
  logic signed [9:0] v_sum;
  logic [7:0]        v_sat;
  logic              fire;

  // 10-bit headroom covers V - leak + I over the full 8-bit input ranges.
  always_comb begin
    v_ext = {{2{v_q[7]}}, v_q};
    i_ext = {{2{input_current[7]}}, input_current};
    leak  = v_ext >>> DECAY_SHIFT;
    v_sum = v_ext - leak + i_ext;
    if (v_sum > 10'sd127) begin
      v_sat = 8'h7f;
    end else if (v_sum < -10'sd128) begin
      v_sat = 8'h80;
    end else begin
      v_sat = v_sum[7:0];
    end
    // Negative potentials never fire; threshold > 127 is unreachable.
    fire = ~v_sat[7] && (v_sat >= threshold);
  end

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    spk_d   = 1'b0;
    ref_d   = ref_q;
    if (enable) begin
      unique case (state_q)
        ST_INT: begin
          if (fire) begin
            v_d   = V_RESET;
            spk_d = 1'b1;
            if (refractory_period != 8'd0) begin
              cnt_d   = refractory_period;
              state_d = ST_REF;
              ref_d   = 1'b1;
            end
          end else begin
            v_d = v_sat;
          end
        end
        ST_REF: begin
          v_d   = V_RESET;
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = ST_INT;
            ref_d   = 1'b0;
          end
        end
        default: begin
          state_d = ST_INT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INT;
      v_q     <= 8'd0;
      cnt_q   <= 8'd0;
      spk_q   <= 1'b0;
      ref_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      spk_q   <= spk_d;
      ref_q   <= ref_d;
    end
  end

  assign membrane_potential = v_q;
  assign spike_out          = spk_q;
  assign refractory         = ref_q;

endmodule

// File: doc/lif_neuron_refractory.md
Name: lif_neuron_refractory

Overview:
Leaky integrate-and-fire neuron stage that sits directly downstream of the input-current calculator. It consumes the signed 8-bit input current once per timestep and integrates it into a saturating membrane potential with shift-based leak. It emits a one-cycle spike when the potential reaches threshold, then enters a programmable refractory period. The spike output feeds the next layer's spike/delay fabric.

Parameters:
DECAY_SHIFT, 3, leak = V >>> DECAY_SHIFT (arithmetic shift), legal range 1..7
V_RESET, 0, signed 8-bit potential loaded after a spike

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  timestep strobe; one integration/refractory step per clk edge with enable=1
input_current  input  8  signed two's-complement current from upstream stage
threshold  input  8  unsigned firing threshold, sampled on every enabled step
refractory_period  input  8  unsigned number of enabled steps ignored after a spike, sampled at fire
membrane_potential  output  8  signed registered potential V
spike_out  output  1  registered one-cycle spike pulse
refractory  output  1  high while in REFRACTORY state

Behaviour:
- Synchronous reset is the only reset. On reset: V=0, spike_out=0, refractory=0, counter=0, state=INTEGRATE. Reset has priority over enable.
- States: INTEGRATE and REFRACTORY. Counter is 8 bits.
- enable=0: state, V and counter hold. spike_out is forced to 0 on every clk edge.
- INTEGRATE with enable=1:
  - Compute V_next = V - (V >>>DECAY_SHIFT) + input_current in at least 10-bit signed arithmetic.
  - Saturate V_next to [-128, 127].
  - Fire condition: V_next >= 0 and V_next (zero-extended) >= threshold.
  - On fire: V <= V_RESET and spike_out <= 1.
    - If refractory_period == 0, stay in INTEGRATE.
    - Otherwise counter <= refractory_period, state <= REFRACTORY, refractory <= 1.
  - No fire: V <= V_next, spike_out <= 0.
- REFRACTORY with enable=1:
  - input_current is ignored, V holds V_RESET, spike_out <= 0.
  - counter decrements.
  - When counter == 1 at the enabled edge: state <= INTEGRATE, refractory <= 0.
  - Exactly refractory_period enabled steps are skipped; the next enabled step integrates.
- Latency: spike_out and V update on the same clk edge that samples enable. spike_out is high for exactly one clk cycle even if enable stays high, unless the neuron fires again on the next step (refractory_period=0).
- Boundaries:
  - threshold = 0 fires on any non-negative V_next.
  - threshold > 127 never fires.
  - -1 >>> DECAY_SHIFT = -1, so a negative V leaks toward 0.
  - Saturation applies before the threshold compare.
  - Changes to threshold or refractory_period while in REFRACTORY do not affect the current period.

Test Plan:
- Reset check: assert reset for 2 cycles with enable=1 and input_current=50 -> V=0, spike_out=0, refractory=0. First enabled step after release gives V=50.
- Integrate/fire: DECAY_SHIFT=3, threshold=50, I=20, refractory_period=2, enable held high:
  - V goes 20, 38, then fires on step 3 (54 >= 50): spike_out=1 for one cycle, V=0, refractory=1.
  - The next 2 steps are ignored.
  - Step 6 gives V=20 and refractory=0.
- Saturation/leak, threshold=200:
  - I=127 repeated -> V goes 127, 127 (239 saturated) and never spikes.
  - Then I=0 -> V goes 112, 98, 86.
  - Reset, then I=-128 repeated -> V goes -128, -128 (-240 saturated).
- Sparse enable: I=20 with enable high one cycle in four -> V changes only on enabled edges (20, 38, fire). spike_out is a single-cycle pulse. Nothing changes between strobes.
- Reset mid-refractory: fire with refractory_period=5, then assert reset after 2 steps -> refractory=0, V=0. The next enabled step integrates I.
- Zero refractory / zero threshold: refractory_period=0, threshold=0, I=0 -> spike_out=1 on every enabled step and refractory stays 0.
